// File: rtl/isp_1bit_morph.sv
// isp_1bit_morph: 3x3 binary erosion/dilation with line buffers, border padding and end-of-frame flush.
module isp_1bit_morph #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_en,
  input  logic        img_1bit_in,
  input  logic [1:0]  mode,
  input  logic [8:0]  kernel_mask,
  output logic        morph_wr_en,
  output logic        img_1bit_out,
  output logic [15:0] morph_data,
  output logic        frame_done,
  output logic        drop_err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);
  localparam logic [CW-1:0] W_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] H_LAST = RW'(IMG_H - 1);
  localparam logic [FW-1:0] F_LAST = FW'(IMG_W);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state;
  logic [CW-1:0] in_col, c_col;
  logic [RW-1:0] in_row, c_row;
  logic [FW-1:0] f_cnt;
  logic [1:0] mode_l, s1_mode, s2_mode;
  logic [8:0] mask_l, s1_mask;
  logic [IMG_W-1:0] lb1, lb2;
  logic [2:0][2:0] win, e;
  logic [2:0] r, s2_r;
  logic s1_v, s1_last, s1_top, s1_bot, s1_lft, s1_rgt, s2_v, s2_last, s2_c;
  logic ev, emit, pix, s1_ero, res;
  assign ev = (state == FLUSH) || wr_en;
  assign emit = ev && (state == RUN || state == FLUSH);
  assign pix = (state != FLUSH) && img_1bit_in;
  assign s1_ero = s1_mode == 2'b01;
  assign res = s2_mode == 2'b01 ? &s2_r : s2_mode == 2'b10 ? |s2_r : s2_c;
  // Out-of-image and masked-off positions both collapse to the reduction identity, which equals the pad value.
  always_comb begin
    e = '0;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++)
        e[i][j] = s1_mask[3*i+j] && !((i == 0 && s1_top) || (i == 2 && s1_bot) || (j == 0 && s1_lft) || (j == 2 && s1_rgt)) ? win[i][j] : s1_ero;
      r[i] = s1_ero ? &e[i] : |e[i];
    end
  end
  always_ff @(posedge sys_clk)
    if (ev) begin
      lb1    <= {lb1[IMG_W-2:0], pix};
      lb2    <= {lb2[IMG_W-2:0], lb1[IMG_W-1]};
      win[2] <= {pix, win[2][2:1]};
      win[1] <= {lb1[IMG_W-1], win[1][2:1]};
      win[0] <= {lb2[IMG_W-1], win[0][2:1]};
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      in_col <= '0;
      in_row <= '0;
      c_col <= '0;
      c_row <= '0;
      f_cnt <= '0;
      mode_l <= '0;
      mask_l <= '0;
      drop_err <= 1'b0;
      {s1_v, s1_last, s1_top, s1_bot, s1_lft, s1_rgt} <= '0;
      s1_mode <= '0;
      s1_mask <= '0;
      {s2_v, s2_last, s2_c} <= '0;
      s2_mode <= '0;
      s2_r <= '0;
      morph_wr_en <= 1'b0;
      img_1bit_out <= 1'b0;
      morph_data <= '0;
      frame_done <= 1'b0;
    end else begin
      drop_err <= drop_err | (wr_en && state == FLUSH);
      case (state)
        IDLE: if (wr_en) begin
          state <= FILL;
          mode_l <= mode;
          mask_l <= kernel_mask;
          in_col <= CW'(1);
          in_row <= '0;
        end
        FILL, RUN: if (wr_en) begin
          in_col <= in_col == W_LAST ? '0 : in_col + 1'b1;
          in_row <= in_col == W_LAST ? in_row + 1'b1 : in_row;
          if (state == FILL && in_row == RW'(1) && in_col == '0) state <= RUN;
          if (state == RUN && in_row == H_LAST && in_col == W_LAST) begin
            state <= FLUSH;
            in_row <= '0;
          end
        end
        FLUSH: begin
          f_cnt <= f_cnt == F_LAST ? '0 : f_cnt + 1'b1;
          if (f_cnt == F_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (emit) begin
        c_col <= c_col == W_LAST ? '0 : c_col + 1'b1;
        c_row <= c_col == W_LAST ? (c_row == H_LAST ? '0 : c_row + 1'b1) : c_row;
      end
      s1_v <= emit;
      s1_last <= state == FLUSH && f_cnt == F_LAST;
      s1_mode <= mode_l;
      s1_mask <= mask_l;
      s1_top <= c_row == '0;
      s1_bot <= c_row == H_LAST;
      s1_lft <= c_col == '0;
      s1_rgt <= c_col == W_LAST;
      s2_v <= s1_v;
      s2_last <= s1_v && s1_last;
      s2_mode <= s1_mode;
      s2_r <= r;
      s2_c <= win[1][1];
      morph_wr_en <= s2_v;
      img_1bit_out <= s2_v && res;
      morph_data <= {16{s2_v && res}};
      frame_done <= s2_v && s2_last;
    end
endmodule

// File: tb/tb_isp_1bit_morph.sv
// tb_isp_1bit_morph: directed frames on an 8x6 image, scoreboard of reference-model outputs checked by a monitor.
module tb_isp_1bit_morph;
  localparam int W = 8, H = 6, N = W * H;
  logic clk = 0, rst_n = 0, wr_en = 0, pix = 0;
  logic [1:0] mode = 0;
  logic [8:0] mask = 0;
  logic morph_wr_en, img_1bit_out, frame_done, drop_err;
  logic [15:0] morph_data;
  typedef struct {logic b; logic d;} exp_t;
  exp_t sb[$];
  bit img[N];
  bit cap[64];
  int out_cnt = 0, first_cyc = 0, t9 = 0, cyc = 0, errors = 0, checks = 0;

  isp_1bit_morph #(.IMG_W(W), .IMG_H(H)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .wr_en(wr_en), .img_1bit_in(pix),
    .mode(mode), .kernel_mask(mask), .morph_wr_en(morph_wr_en),
    .img_1bit_out(img_1bit_out), .morph_data(morph_data),
    .frame_done(frame_done), .drop_err(drop_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (morph_wr_en) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          exp_t x;
          x = sb.pop_front();
          chk("pixel", img_1bit_out, x.b);
          chk("morph_data", morph_data, x.b ? 16'hFFFF : 16'h0000);
          chk("frame_done", frame_done, x.d);
        end
        if (out_cnt == 0) first_cyc = cyc;
        if (out_cnt < 64) cap[out_cnt] = img_1bit_out;
        out_cnt++;
      end else chk("idle_outputs_zero", {img_1bit_out, morph_data, frame_done}, 0);
    end

  task automatic push_frame(input logic [1:0] md, input logic [8:0] mk);
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++) begin
        bit acc;
        if (md == 2'b01 || md == 2'b10) begin
          bit ero;
          ero = md == 2'b01;
          acc = ero;
          for (int di = -1; di <= 1; di++)
            for (int dj = -1; dj <= 1; dj++)
              if (mk[(di+1)*3 + dj + 1]) begin
                bit v;
                int y, x;
                y = rr + di;
                x = cc + dj;
                v = (y < 0 || y >= H || x < 0 || x >= W) ? ero : img[y*W + x];
                acc = ero ? (acc & v) : (acc | v);
              end
        end else acc = img[rr*W + cc];
        sb.push_back('{b: acc, d: (rr == H-1 && cc == W-1)});
      end
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() > 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    repeat (4) @(negedge clk);
    chk("output_count", out_cnt, N);
  endtask

  task automatic send(input logic [1:0] md, input logic [8:0] mk, input bit gaps, input bit poke,
                      input int chg_at, input logic [1:0] md2);
    push_frame(md, mk);
    out_cnt = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (gaps)
        while ($urandom_range(0, 1) == 1) begin
          wr_en = 0;
          @(negedge clk);
        end
      wr_en = 1;
      pix = img[i];
      mode = (chg_at >= 0 && i >= chg_at) ? md2 : md;
      mask = (chg_at >= 0 && i >= chg_at) ? 9'h0 : mk;
      if (i == 9) t9 = cyc;
    end
    @(negedge clk);
    wr_en = poke;
    if (poke) begin
      repeat (3) @(negedge clk);
      wr_en = 0;
    end
    wait_done();
  endtask

  function automatic int ones();
    int s = 0;
    for (int i = 0; i < N; i++) s += cap[i];
    return s;
  endfunction

  task automatic set_single(input bit bg, input int rr, input int cc);
    for (int i = 0; i < N; i++) img[i] = bg;
    img[rr*W + cc] = !bg;
  endtask

  initial begin
    int s;
    wr_en = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {morph_wr_en, img_1bit_out, morph_data, frame_done, drop_err}, 0);
    wr_en = 0;
    rst_n = 1;
    for (int i = 0; i < N; i++) img[i] = (i % 3 == 0) ^ (i % 5 == 1);
    send(2'b00, 9'h1FF, 0, 0, -1, 2'b00);
    chk("first_out_latency", first_cyc - t9, 3);
    s = 0;
    for (int i = 0; i < N; i++) s += (cap[i] == img[i]);
    chk("bypass_equal_input", s, N);

    for (int i = 0; i < N; i++) img[i] = 1;
    send(2'b01, 9'h1FF, 0, 0, -1, 2'b00);
    chk("ero_all_ones", ones(), 48);
    set_single(1, 2, 3);
    send(2'b01, 9'h1FF, 0, 0, -1, 2'b00);
    chk("ero_zero_count", N - ones(), 9);
    s = 0;
    for (int rr = 1; rr <= 3; rr++) for (int cc = 2; cc <= 4; cc++) s += !cap[rr*W + cc];
    chk("ero_zero_block", s, 9);

    set_single(0, 0, 0);
    send(2'b10, 9'h1FF, 0, 0, -1, 2'b00);
    chk("dil_corner_count", ones(), 4);
    chk("dil_corner_pos", cap[0] + cap[1] + cap[8] + cap[9], 4);
    set_single(0, 2, 7);
    send(2'b10, 9'h1FF, 0, 0, -1, 2'b00);
    s = 0;
    for (int rr = 0; rr < H; rr++) s += cap[rr*W];
    chk("dil_no_wrap_col0", s, 0);
    chk("dil_edge_count", ones(), 6);

    set_single(0, 3, 3);
    send(2'b10, 9'h0BA, 0, 0, -1, 2'b00);
    chk("cross_count", ones(), 5);
    chk("cross_pos", cap[19] + cap[26] + cap[27] + cap[28] + cap[35], 5);
    send(2'b10, 9'h000, 0, 0, -1, 2'b00);
    chk("empty_mask_zero", ones(), 0);

    for (int i = 0; i < N; i++) img[i] = ($urandom_range(0, 3) == 0);
    send(2'b10, 9'h155, 1, 0, 20, 2'b01);
    for (int i = 0; i < N; i++) img[i] = ($urandom_range(0, 7) != 0);
    send(2'b01, 9'h1FF, 1, 0, -1, 2'b00);
    send(2'b11, 9'h1FF, 1, 0, -1, 2'b00);

    chk("drop_err_clear_before", drop_err, 0);
    send(2'b01, 9'h0BA, 0, 1, -1, 2'b00);
    chk("drop_err_set", drop_err, 1);
    repeat (5) @(negedge clk);
    chk("drop_err_sticky", drop_err, 1);

    push_frame(2'b00, 9'h0);
    out_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_en = 1;
      pix = img[i];
      mode = 2'b00;
    end
    @(negedge clk);
    wr_en = 0;
    #2 rst_n = 0;
    #1 chk("reset_mid_run_valid", morph_wr_en, 0);
    sb.delete();
    chk("reset_clears_drop_err", drop_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < N; i++) img[i] = ($urandom_range(0, 1) == 1);
    send(2'b10, 9'h1FF, 0, 0, -1, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/isp_1bit_morph.md
# isp_1bit_morph

Parametrised 3x3 binary morphology stage for the 1-bit ISP path. It replaces the fixed erosion/dilation stages. It holds its own two line buffers and row/column counters, which give it:
- correct image-border padding and no horizontal wrap;
- a runtime-selectable mode (bypass / erosion / dilation) and 9-bit structuring-element mask;
- an end-of-frame flush, so that exactly IMG_W*IMG_H pixels leave per frame.

It sits between binarisation and the RGB565 frame writer.

## Interface
- IMG_W, 640, pixels per line (>=2)
- IMG_H, 480, lines per frame (>=2)

- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  input pixel valid; arbitrary gaps allowed
- img_1bit_in  in  1  input pixel, raster order
- mode  in  2  00 bypass, 01 erosion, 10 dilation, 11 treated as bypass
- kernel_mask  in  9  bit[3*i+j] enables window position row i, col j (i,j 0..2, 0 = top/left; bit4 = centre)
- morph_wr_en  out  1  output pixel valid
- img_1bit_out  out  1  result pixel; forced 0 when morph_wr_en=0
- morph_data  out  16  16'hFFFF when img_1bit_out=1, else 16'h0000
- frame_done  out  1  one-cycle pulse coincident with the last output pixel of a frame
- drop_err  out  1  sticky; set when wr_en is high during FLUSH

## Operation
- Pixel "events": an accepted input (wr_en=1 in IDLE/FILL/RUN) or one internal flush cycle.
  - Each event shifts the window. Two IMG_W-bit line buffers supply the upper rows.
  - Newest pixel sits at window (2,2); the window centre is pixel n-IMG_W-1.
- State machine:
  - IDLE: on wr_en, accept pixel 0, latch mode and kernel_mask for the whole frame, go to FILL.
  - FILL: accept pixels 1..IMG_W with no output; after accepting index IMG_W, go to RUN.
  - RUN: each accepted pixel (index IMG_W+1 .. IMG_W*IMG_H-1) emits one output. After the last index, go to FLUSH.
  - FLUSH: IMG_W+1 consecutive internal events (one per cycle), each emitting one output, then go to IDLE. wr_en in FLUSH is ignored and sets drop_err.
- Border padding:
  - A window position is out of image if it lies outside either of these ranges (relative to the centre's row/col):
    - rows 0..IMG_H-1;
    - cols 0..IMG_W-1.
  - Out-of-image positions take the pad value: 1 for erosion, 0 for dilation.
  - Left/right neighbours never wrap across line ends. Flush positions are always out of image.
- Result per centre:
  - erosion = AND over enabled positions (all-zero mask -> 1);
  - dilation = OR over enabled positions (all-zero mask -> 0);
  - bypass = centre pixel, mask ignored.
- Line-buffer contents are never cleared; padding alone defines the top rows.
- Output count per frame is exactly IMG_W*IMG_H, in raster order of centres.

## Timing
- Reset values: morph_wr_en=0, img_1bit_out=0, morph_data=16'h0000, frame_done=0, drop_err=0; state=IDLE; all counters 0.
- Latency: fixed 3 cycles. An event in cycle T gives morph_wr_en=1 with valid data in cycle T+3.
  - Pipeline: window register, then row reduction, then combine/output register.
- First output of a frame: 3 cycles after input index IMG_W+1 is accepted.
- With a continuous input, the last output is 3 cycles after the last FLUSH event. frame_done is asserted in that same cycle.
- Input gaps during FILL/RUN stall events; the output gaps mirror them.
- The next frame's first wr_en is accepted in the cycle after FLUSH ends (IDLE). Pixels arriving during FLUSH are lost, and drop_err is set.
- Reset mid-frame:
  - all outputs drop to reset values asynchronously;
  - in-flight pipeline data is discarded;
  - the next wr_en after reset release is pixel 0 of a new frame.
- mode/kernel_mask changes mid-frame have no effect until the next IDLE->FILL.
- Counter widths: $clog2(IMG_W), $clog2(IMG_H), $clog2(IMG_W+2) for flush.

## Test plan
All scenarios use IMG_W=8, IMG_H=6.
- Reset, then idle: all outputs at reset values. Release reset, drive 48 wr_en pulses in bypass:
  - first morph_wr_en 3 cycles after the 10th pulse (index 9);
  - 48 outputs equal to the inputs in order;
  - frame_done with the 48th output.
- Erosion, mask 9'h1FF, all-ones frame: 48 ones, including borders. Same with a single 0 at (r2,c3): exactly 9 zeros, at rows 1-3, cols 2-4.
- Dilation, mask 9'h1FF, single 1 at (0,0): ones only at (0,0),(0,1),(1,0),(1,1). Single 1 at (2,7): no 1 in column 0 of any row.
- Dilation, mask 9'h0BA (cross), single 1 at (3,3): exactly 5 ones, at (2,3),(3,2),(3,3),(3,4),(4,3). Mask 9'h000: all zeros.
- Random wr_en gaps (50% duty) vs the golden model: identical output sequence, still 48 outputs. A mode change mid-frame takes effect only on the next frame.
- wr_en high during FLUSH:
  - drop_err=1 and stays set;
  - frame still yields 48 outputs.
- Reset asserted mid-RUN: morph_wr_en=0 immediately, and the following full frame matches the model.
